// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default sizes for the ARM load hazard scoreboard (package arm_hazard_pkg).
package arm_hazard_pkg;

    localparam int DEF_REG_W    = 4;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_DEPTH    = 4;

    // Lower encodings win when several stall reasons are active at once.
    typedef enum logic [2:0] {
        NONE     = 3'd0,
        LOAD_USE = 3'd1,
        PENDING  = 3'd2,
        WAW      = 3'd3,
        LSQ_FULL = 3'd4,
        NO_FWD   = 3'd5
    } hazard_cause_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard scoreboard: ID/EXE/MEM operand info in, stall request out.
interface hazard_scoreboard_if #(
    parameter int REG_W = arm_hazard_pkg::DEF_REG_W
);
    import arm_hazard_pkg::*;

    // Level signals sampled every cycle; no valid/ready handshake. rsp_valid is a
    // one-cycle pulse meaning "the oldest outstanding load returns now".
    logic             freeze;
    logic             fwd_en;
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_src2;
    logic             id_src1_used;
    logic             id_two_src;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_read;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             rsp_valid;
    logic             hazard;
    hazard_cause_t    hazard_cause;

    modport master (
        output freeze, fwd_en, id_valid, id_rn, id_src2, id_src1_used, id_two_src,
               id_dest, id_wb_en, id_mem_read, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, rsp_valid,
        input  hazard, hazard_cause
    );

    modport slave (
        input  freeze, fwd_en, id_valid, id_rn, id_src2, id_src1_used, id_two_src,
               id_dest, id_wb_en, id_mem_read, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, rsp_valid,
        output hazard, hazard_cause
    );

endinterface

// File: rtl/load_dest_fifo.sv
// In-order FIFO of destination registers for outstanding loads; head is the next load to return.
module load_dest_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) rptr <= next_ptr(rptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load hazard scoreboard beside ID: tracks outstanding loads and raises hazard/hazard_cause.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/load_use_stalls counters (tied to 0 otherwise).
module hazard_scoreboard
    import arm_hazard_pkg::*;
#(
    parameter int REG_W    = DEF_REG_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   hz,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 lsq_full,
    output logic                 rsp_err,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          load_use_stalls
);
    logic [REG_W-1:0]    head;
    logic [CNT_W-1:0]    count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                issue;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic [CNT_W-1:0]    pend [NUM_REGS];
    logic [NUM_REGS-1:0] pend_inc;
    logic [NUM_REGS-1:0] pend_dec;
    logic [CNT_W:0]      occ_next;
    logic                t_load_use;
    logic                t_pending;
    logic                t_waw;
    logic                t_lsq_full;
    logic                t_no_fwd;

    assign issue   = hz.exe_mem_read & hz.exe_wb_en & ~hz.freeze;
    assign pop     = hz.rsp_valid & ~fifo_empty;
    assign push_ok = issue & (~fifo_full | pop);
    assign drop    = issue & ~push_ok;

    load_dest_fifo #(.W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .din   (hz.exe_dest),
        .head  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign outstanding = count;
    assign lsq_full    = fifo_full;

    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_inc[i] = push_ok && (hz.exe_dest == REG_W'(i));
            pend_dec[i] = pop && (head == REG_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                case ({pend_inc[i], pend_dec[i]})
                    2'b10: if (pend[i] != CNT_W'(DEPTH)) pend[i] <= pend[i] + CNT_W'(1);
                    2'b01: if (pend[i] != '0) pend[i] <= pend[i] - CNT_W'(1);
                    default: pend[i] <= pend[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) rsp_err <= 1'b0;
        else if ((hz.rsp_valid & fifo_empty) | drop) rsp_err <= 1'b1;
    end

    // The last copy of r returning this cycle is forwarded/written now, so r is free.
    function automatic logic busy(input logic [REG_W-1:0] r);
        return (pend[r] != '0) && !((pend[r] == CNT_W'(1)) && pop && (head == r));
    endfunction

    function automatic logic src_hit(input logic [REG_W-1:0] r);
        return (hz.id_src1_used && (hz.id_rn == r)) || (hz.id_two_src && (hz.id_src2 == r));
    endfunction

    assign occ_next = {1'b0, count} + (CNT_W + 1)'(issue) - (CNT_W + 1)'(pop);

    always_comb begin
        t_load_use = hz.id_valid && hz.exe_mem_read && src_hit(hz.exe_dest);
        t_pending  = hz.id_valid && ((hz.id_src1_used && busy(hz.id_rn)) ||
                                     (hz.id_two_src && busy(hz.id_src2)));
        t_waw      = hz.id_valid && hz.id_wb_en && busy(hz.id_dest);
        t_lsq_full = hz.id_valid && hz.id_mem_read && (occ_next >= (CNT_W + 1)'(DEPTH));
        t_no_fwd   = hz.id_valid && !hz.fwd_en &&
                     ((hz.exe_wb_en && src_hit(hz.exe_dest)) ||
                      (hz.mem_wb_en && src_hit(hz.mem_dest)));

        hz.hazard       = t_load_use | t_pending | t_waw | t_lsq_full | t_no_fwd;
        hz.hazard_cause = NONE;
        if (t_load_use)      hz.hazard_cause = LOAD_USE;
        else if (t_pending)  hz.hazard_cause = PENDING;
        else if (t_waw)      hz.hazard_cause = WAW;
        else if (t_lsq_full) hz.hazard_cause = LSQ_FULL;
        else if (t_no_fwd)   hz.hazard_cause = NO_FWD;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] lu_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            lu_q    <= '0;
        end else begin
            if (hz.hazard && !hz.freeze) stall_q <= stall_q + 32'd1;
            if (hz.hazard_cause == LOAD_USE) lu_q <= lu_q + 32'd1;
        end
    end

    assign stall_cycles    = stall_q;
    assign load_use_stalls = lu_q;
`else
    assign stall_cycles    = '0;
    assign load_use_stalls = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard detection unit for the ARM pipeline with forwarding and a non-blocking, in-order data memory. It sits beside the ID stage and tracks outstanding loads in a destination FIFO with per-register pending counters. From these it asserts `hazard` (freezes PC/IF/ID, bubbles EXE) on load-use, pending-load, write-after-write and load-queue-full conditions. It also supports a no-forwarding mode for debug.

## Interface
Parameters:
- `REG_W`, 4: register index width.
- `NUM_REGS`, 16: architectural registers tracked.
- `DEPTH`, 4: maximum outstanding loads, ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`: width of occupancy and per-register counters.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `freeze` in 1: global pipeline freeze; no load is issued while high.
- `fwd_en` in 1: 1 = forwarding mode, 0 = no-forwarding mode.
- `id_valid` in 1: ID holds a real instruction (low after flush).
- `id_rn`, `id_src2` in REG_W: ID source registers.
- `id_src1_used`, `id_two_src` in 1: source-valid qualifiers.
- `id_dest` in REG_W: ID destination register.
- `id_wb_en`, `id_mem_read` in 1: ID destination register write enable; ID instruction is a load.
- `exe_dest` in REG_W: EXE destination register.
- `exe_wb_en`, `exe_mem_read` in 1: EXE destination register write enable; EXE instruction is a load.
- `mem_dest` in REG_W, `mem_wb_en` in 1: MEM-stage destination register and write enable; used only when `fwd_en`=0.
- `rsp_valid` in 1: memory returns the oldest outstanding load this cycle.
- `hazard` out 1: stall request, combinational.
- `hazard_cause` out 3: encoded reason, combinational.
- `outstanding` out CNT_W: registered load-queue occupancy.
- `lsq_full` out 1: `outstanding == DEPTH`.
- `rsp_err` out 1: sticky; set when a response arrives with the queue empty.
- `stall_cycles` out 32: performance counter.
- `load_use_stalls` out 32: performance counter.

## Operation
- Load issue: `issue = exe_mem_read & exe_wb_en & ~freeze`.
  - Pushes `exe_dest` into the FIFO.
  - Increments `pend[exe_dest]`.
- Load return: `pop = rsp_valid & (outstanding != 0)`.
  - Pops the FIFO head `h`.
  - Decrements `pend[h]`.
  - `rsp_valid` with the queue empty sets `rsp_err`; no pop, no counter change.
- Simultaneous issue and pop:
  - Occupancy is unchanged.
  - If `exe_dest == h`, `pend[h]` is unchanged.
- Issue while full is impossible by construction. If it occurs, the push is dropped and `rsp_err` is set.
- Effective pending: `busy(r) = pend[r] != 0`, except when `pend[r] == 1 & pop & h == r`. In that case the returning data is forwarded/written this cycle and `r` is not busy.
- Hazard terms, all gated by `id_valid`; `hazard` is the OR of all terms:
  - LOAD_USE (1): `exe_mem_read` and the EXE dest matches a used source (`id_rn` when `id_src1_used`; `id_src2` when `id_two_src`).
  - PENDING (2): a used source is `busy`.
  - WAW (3): `id_wb_en & busy(id_dest)`.
  - LSQ_FULL (4): `id_mem_read` and the queue would be full on the ID load's issue. Condition: `outstanding + issue - pop >= DEPTH`.
  - NO_FWD (5): `fwd_en`=0 and a used source matches `exe_dest` (with `exe_wb_en`) or `mem_dest` (with `mem_wb_en`).
- `hazard_cause` reports the lowest-numbered active term; 0 when `hazard` is 0.
- Counter arithmetic:
  - `pend[r]` saturates at DEPTH and never wraps below 0.
  - `outstanding` is always the sum of all `pend`.

## Timing
- `hazard` and `hazard_cause` are combinational from inputs and current state, with zero latency.
- FIFO, `pend`, `outstanding` and `rsp_err` update on the rising edge.
- Issue-to-visible: a load in EXE at cycle t appears in `pend` at t+1.
  - During cycle t it is covered by LOAD_USE, so there is no gap.
- Reset (`rst`=0 at an edge) clears every state element, including mid-stream outstanding loads:
  - FIFO empty, `pend` all 0, `outstanding`=0, `lsq_full`=0, `rsp_err`=0, perf counters 0.
  - With `id_valid`=0 after reset, `hazard`=0 and `hazard_cause`=0.
- Branch flush: loads already issued remain tracked. Only the ID term is suppressed, via `id_valid`.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments every cycle `hazard`=1 and `freeze`=0.
  - `load_use_stalls` increments when `hazard_cause`==1.
  - Both counters wrap at 2^32.
- `HAZARD_PERF_CNT_EN` undefined: both outputs are tied to 0 and no counter flops are generated.

## Structure
- Package `arm_hazard_pkg`:
  - `hazard_cause_t` enum: NONE=0, LOAD_USE=1, PENDING=2, WAW=3, LSQ_FULL=4, NO_FWD=5.
  - Default REG_W/NUM_REGS/DEPTH constants.
- Sub-module `load_dest_fifo`: parametrised synchronous FIFO (REG_W wide, DEPTH deep) with push/pop, head, count, full/empty. The scoreboard counters live in the top.

## Test plan
- Load-use: EXE `ldr r3`, ID `add r1,r3,r2` → `hazard`=1, cause 1. Next cycle (load in MEM, no `rsp_valid`) → cause 2.
- Same-cycle return: `pend[r3]`=1, `rsp_valid`=1 with head r3, ID reads r3 → `hazard`=0. Following cycle `outstanding`=0.
- Queue full at DEPTH=4: issue four loads with no responses, ID load → `hazard`=1, cause 4, `lsq_full`=1. Assert `rsp_valid` → `hazard` drops in the same cycle.
- Double load: two loads to r5 outstanding, one response → `pend[r5]`=1 and an ID read of r5 still stalls. Second response → no stall.
- WAW: `pend[r7]`=1, ID `mov r7,#1` → cause 3. With `fwd_en`=0, EXE writes r2 and ID reads r2 → cause 5.
- Reset with 3 loads outstanding → all state cleared. Then `rsp_valid` with an empty queue → `rsp_err`=1 and it stays set until the next reset.
